// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the counter sizing rule.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit run still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple of full-adder cells.
// Also exposes the carry into the top bit for overflow detection.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co       = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: parallel load, LSB-first processing,
// one ripple slice and a registered carry, start/done handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [DIGIT-1:0] s;
    logic             co;
    logic             c_msb_in;
    logic             last;

    addsub_digit #(.DIGIT(DIGIT)) u_slice (
        .x        (a_sr[DIGIT-1:0]),
        .y        (b_sr[DIGIT-1:0]),
        .ci       (carry),
        .s        (s),
        .co       (co),
        .c_msb_in (c_msb_in)
    );

    // New digit enters at the top so the first digit ends at bit 0.
    always_comb begin
        acc_next                   = acc >> DIGIT;
        acc_next[WIDTH-1 -: DIGIT] = s;
    end

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum      <= acc_next;
                        cout     <= co;
                        overflow <= c_msb_in ^ co;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: bit-serial and 4-bit-digit instances
// checked each cycle against an arithmetic model plus literal vectors.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_v [2];
    logic       sub_v   [2];
    logic       cin_v   [2];
    logic [7:0] a_v     [2];
    logic [7:0] b_v     [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       cout_v  [2];
    logic       ovf_v   [2];
    logic [7:0] sum_v   [2];

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    int         m_rem  [2];
    logic       m_busy [2];
    logic       m_done [2];
    logic       m_cout [2];
    logic       m_ovf  [2];
    logic [7:0] m_sum  [2];
    logic       p_cout [2];
    logic       p_ovf  [2];
    logic [7:0] p_sum  [2];

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_bit (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]),
        .overflow(ovf_v[0])
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_nib (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]),
        .overflow(ovf_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int nsteps(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    // Result from plain integer arithmetic on the operands.
    task automatic calc(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic c,
                        output logic [7:0] r, output logic co,
                        output logic ov);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!s) begin
            ur = ua + ub + int'(c);
            sr = sa + sb + int'(c);
            co = (ur > 255);
        end else begin
            ur = ua - ub - int'(c);
            sr = sa - sb - int'(c);
            co = (ur >= 0);
        end
        r  = ur[7:0];
        ov = (sr > 127) || (sr < -128);
    endtask

    task automatic model_step(input int i);
        if (rst) begin
            m_rem[i]  = 0;
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_sum[i]  = 8'h00;
            m_cout[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end else if (m_rem[i] == 0) begin
            m_done[i] = 1'b0;
            m_busy[i] = 1'b0;
            if (start_v[i]) begin
                calc(a_v[i], b_v[i], sub_v[i], cin_v[i],
                     p_sum[i], p_cout[i], p_ovf[i]);
                m_rem[i]  = nsteps(i);
                m_busy[i] = 1'b1;
            end
        end else begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
                m_sum[i]  = p_sum[i];
                m_cout[i] = p_cout[i];
                m_ovf[i]  = p_ovf[i];
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cmp busy[%0d]", i), 32'(busy_v[i]), 32'(m_busy[i]));
                chk($sformatf("cmp done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
                chk($sformatf("cmp sum[%0d]", i), 32'(sum_v[i]), 32'(m_sum[i]));
                chk($sformatf("cmp cout[%0d]", i), 32'(cout_v[i]), 32'(m_cout[i]));
                chk($sformatf("cmp ovf[%0d]", i), 32'(ovf_v[i]), 32'(m_ovf[i]));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge showing done.
    task automatic do_op(input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic s,
                         input logic c, output int lat);
        a_v[i]     = a;
        b_v[i]     = b;
        sub_v[i]   = s;
        cin_v[i]   = c;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        lat = 1;
        while (!done_v[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done_v[i]) begin
            checks++;
            errors++;
            $display("FAIL timeout[%0d]: no done after %0d cycles", i, lat);
        end
    endtask

    task automatic lit(input string name, input int i, input int lat,
                       input int elat, input logic [7:0] es,
                       input logic ec, input logic eo);
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " sum"}, 32'(sum_v[i]), 32'(es));
        chk({name, " cout"}, 32'(cout_v[i]), 32'(ec));
        chk({name, " ovf"}, 32'(ovf_v[i]), 32'(eo));
        chk({name, " model sum"}, 32'(m_sum[i]), 32'(es));
    endtask

    initial begin
        int lat;
        int dones;
        logic [7:0] cap;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            sub_v[i]   = 1'b0;
            cin_v[i]   = 1'b0;
            a_v[i]     = 8'h00;
            b_v[i]     = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        armed = 1'b1;
        chk("reset busy", 32'(busy_v[0]), 0);
        chk("reset done", 32'(done_v[0]), 0);
        chk("reset sum", 32'(sum_v[0]), 0);
        chk("reset busy4", 32'(busy_v[1]), 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        lit("t1", 0, lat, 9, 8'h96, 1'b1 ^ 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("t1 hold sum", 32'(sum_v[0]), 32'h96);

        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b1, lat);
        lit("t2", 0, lat, 9, 8'h01, 1'b1, 1'b0);
        @(negedge clk);

        do_op(0, 8'h10, 8'h20, 1'b1, 1'b0, lat);
        lit("t3a", 0, lat, 9, 8'hF0, 1'b0, 1'b0);
        do_op(0, 8'h80, 8'h01, 1'b1, 1'b0, lat);
        lit("t3b", 0, lat, 9, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        a_v[0]     = 8'h33;
        b_v[0]     = 8'h11;
        sub_v[0]   = 1'b0;
        cin_v[0]   = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        a_v[0]     = 8'hAA;
        b_v[0]     = 8'h77;
        sub_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        dones = 0;
        cap = 8'h00;
        for (int k = 0; k < 20; k++) begin
            if (done_v[0]) begin
                dones++;
                cap = sum_v[0];
            end
            @(negedge clk);
        end
        chk("t4 done count", 32'(dones), 1);
        chk("t4 sum", 32'(cap), 32'h44);

        a_v[0]     = 8'h12;
        b_v[0]     = 8'h34;
        sub_v[0]   = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5 busy", 32'(busy_v[0]), 0);
        chk("t5 done", 32'(done_v[0]), 0);
        chk("t5 sum", 32'(sum_v[0]), 0);
        chk("t5 cout", 32'(cout_v[0]), 0);
        chk("t5 ovf", 32'(ovf_v[0]), 0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            if (done_v[0]) dones++;
            @(negedge clk);
        end
        chk("t5 no done", 32'(dones), 0);
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, lat);
        lit("t5 fresh", 0, lat, 9, 8'h46, 1'b0, 1'b0);
        @(negedge clk);

        do_op(1, 8'h5A, 8'h3C, 1'b0, 1'b0, lat);
        lit("t6", 1, lat, 3, 8'h96, 1'b0, 1'b1);
        do_op(1, 8'h80, 8'h01, 1'b1, 1'b0, lat);
        lit("t6 sub", 1, lat, 3, 8'h7F, 1'b1, 1'b1);

        for (int k = 0; k < 300; k++) begin
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom), lat);
            chk("sweep4 latency", 32'(lat), 3);
        end
        for (int k = 0; k < 80; k++) begin
            do_op(0, 8'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom), lat);
            chk("sweep1 latency", 32'(lat), 9);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
